pixel_input_packer: RTL and testbench
=====================================

Name: pixel_input_packer

Overview:
- Upstream stage of the histogram equalizer datapath, directly ahead of the mem_controller / top_level_control pair.
- Accepts a byte-per-pixel stream under a valid/ready handshake and packs 16 pixels into each 128-bit input-memory word.
- Writes packed words to input memory from address 0 upward.
- At image end, publishes the word count on input_mem_depth and fires new_image_pulse to start equalization.

Parameters:
- MEM_DEPTH_WORDS, 65536: number of 128-bit words in input memory; write-address limit.
- PIXEL_W, 8: pixel width in bits. Fixed at 8; 16 lanes per word.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_valid  in  1  pixel_data / pixel_last valid this cycle
- pixel_data  in  8  pixel value
- pixel_last  in  1  final pixel of the image
- pixel_ready  out  1  packer accepts a pixel this cycle
- core_busy  in  1  equalizer is still processing the previous image (level)
- input_mem_WE  out  1  input memory write enable
- input_mem_waddr  out  16  input memory write address
- input_mem_wdata  out  128  packed pixel word
- input_mem_depth  out  17  words written for the last image
- pixel_count  out  21  pixels accepted for the last image
- new_image_pulse  out  1  one-cycle start pulse to top_level_control
- input_overflow_fault  out  1  sticky: image exceeded MEM_DEPTH_WORDS

Behaviour:
- Reset (asynchronous) values: all outputs 0 and state IDLE. pixel_ready becomes 1 in the first cycle after reset deassertion if core_busy=0.
- A handshake completes when pixel_valid && pixel_ready. pixel_data and pixel_last are sampled only on a completed handshake.
- Lane packing: the k-th accepted pixel of a word (k = 0..15) goes to bits [8k+7:8k]. Lane 0 holds the first pixel of the word.
- States:
  - IDLE: pixel_ready = !core_busy. The first handshake clears the word counter, the pixel counter and input_overflow_fault, loads lane 0, then moves to FILL. If pixel_last is set on that first pixel, the last-pixel rule below applies.
  - FILL: pixel_ready = 1.
    - On the 16th lane, or on pixel_last, the word is registered. Next cycle: input_mem_WE=1, input_mem_waddr = word counter, input_mem_wdata = the packed word. The word counter then increments.
    - Back-to-back pixels are allowed; the write pipeline sustains 1 pixel/cycle with no stall.
    - pixel_last moves the state to FLUSH.
  - FLUSH: pixel_ready = 0. Waits for the final write cycle to complete.
    - input_mem_depth <= words written (17 bits, so 65536 is representable).
    - pixel_count <= pixels accepted.
    - Then moves to PULSE.
  - PULSE: new_image_pulse = 1 for exactly one cycle, then back to IDLE.
- Latency: last pixel handshake at cycle t → final input_mem_WE at t+1 → input_mem_depth and pixel_count valid at t+2 → new_image_pulse at t+2.
- Overflow:
  - When the word counter equals MEM_DEPTH_WORDS, further writes are suppressed (WE stays 0).
  - input_overflow_fault is set and held until the next image's first handshake.
  - Pixels are still accepted and dropped until pixel_last. input_mem_depth saturates at MEM_DEPTH_WORDS.
  - new_image_pulse still fires; top_level_control sees the fault.
- pixel_count saturates at 2^21-1.
- core_busy rising during FILL has no effect; it only gates the start of a new image in IDLE.
- Reset mid-image: state returns to IDLE and the partial word is discarded. Memory contents are not cleared.
- A pixel_valid with pixel_ready=0 is held by the sender and not lost.

Optional Feature:
- Macro: INPUT_PACKER_PAD_EN.
- Defined: a partial final word (pixel_last on lane k < 15) is written with lanes k+1..15 set to 0x00. input_mem_depth counts that word.
- Not defined: a partial final word is discarded, not written, and not counted in input_mem_depth. pixel_count still counts every accepted pixel. Images whose length is a multiple of 16 behave identically in both builds.

Decomposition:
- Shared package: LANES_PER_WORD=16, PIXEL_W=8, WORD_W=128, ADDR_W=16, DEPTH_W=17, the state enum {IDLE, FILL, FLUSH, PULSE}.
- One natural sub-module: pixel_lane_shifter. It holds the lane index, the packing register and the word-complete strobe.

Test Plan:
- 32 pixels 0x00..0x1F at 1/cycle, pixel_last on 0x1F → WE at addr 0 with wdata 0x0F0E..0100, then addr 1 with 0x1F1E..1110; input_mem_depth=2; pixel_count=32; new_image_pulse 2 cycles after last handshake.
- 20 pixels, pixel_last on 20th → with PAD_EN: depth=2, word 1 lanes 4..15 = 0x00; without: depth=1, only addr 0 written; pixel_count=20 in both.
- core_busy=1 in IDLE with pixel_valid=1 → pixel_ready=0, no WE; drop core_busy → first pixel accepted next cycle.
- MEM_DEPTH_WORDS=2, 48 pixels → writes at addr 0,1 only; input_overflow_fault=1; depth=2; pulse still fires; next image's first pixel clears the fault.
- Random pixel_valid gaps (≈50%) over 64 pixels → packed words match the gap-free result; WE count=4.
- Assert reset after 10 pixels → all outputs 0 immediately; a following 16-pixel image writes addr 0, depth=1.

Source files
------------

// File: rtl/pixel_input_packer_pkg.sv
// Shared constants and state encoding for the pixel input packer.
// Optional build macro: INPUT_PACKER_PAD_EN (zero-pads and writes a partial final word).
package pixel_input_packer_pkg;

    localparam int LANES_PER_WORD = 16;
    localparam int PIXEL_W        = 8;
    localparam int WORD_W         = 128;
    localparam int ADDR_W         = 16;
    localparam int DEPTH_W        = 17;
    localparam int COUNT_W        = 21;
    localparam int LANE_IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        PULSE = 2'd3
    } state_t;

endpackage

// File: rtl/pixel_lane_shifter.sv
// Packs accepted pixels into 16 byte lanes and strobes a completed 128-bit word.
// Optional build macro: INPUT_PACKER_PAD_EN -- when defined, a word closed early by
// pixel_last is emitted with its unfilled lanes at zero; otherwise it is dropped.
module pixel_lane_shifter
    import pixel_input_packer_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               accept,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_last,
    output logic [WORD_W-1:0]  word,
    output logic               word_done
);

`ifdef INPUT_PACKER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic [LANE_IDX_W-1:0] lane_idx_reg;
    logic [WORD_W-1:0]     word_reg;
    logic                  word_done_reg;
    logic [WORD_W-1:0]     word_next;
    logic                  last_lane;
    logic                  closing;
    logic                  emit;

    assign last_lane = (lane_idx_reg == LANE_IDX_W'(LANES_PER_WORD - 1));
    assign closing   = last_lane || pixel_last;
    // A full word is always emitted; a short final word only when padding is built in.
    assign emit      = last_lane || PAD_EN;

    genvar gi;
    generate
        for (gi = 0; gi < LANES_PER_WORD; gi++) begin : g_lane
            logic [PIXEL_W-1:0] lane_reg;
            logic               lane_hit;

            assign lane_hit = (lane_idx_reg == LANE_IDX_W'(gi));

            // Hold this lane's byte; cleared whenever a word closes so unfilled lanes read as zero.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if (accept) begin
                    if (closing) begin
                        lane_reg <= '0;
                    end else if (lane_hit) begin
                        lane_reg <= pixel_data;
                    end
                end
            end

            // The closing pixel is merged straight into the outgoing word.
            assign word_next[gi*PIXEL_W +: PIXEL_W] = lane_hit ? pixel_data : lane_reg;
        end
    endgenerate

    // Advance the lane index and register the completed word with its one-cycle strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane_idx_reg  <= '0;
            word_reg      <= '0;
            word_done_reg <= 1'b0;
        end else begin
            word_done_reg <= accept && closing && emit;
            if (accept && closing && emit) begin
                word_reg <= word_next;
            end
            if (accept) begin
                lane_idx_reg <= closing ? '0 : lane_idx_reg + 1'b1;
            end
        end
    end

    assign word      = word_reg;
    assign word_done = word_done_reg;

endmodule

// File: rtl/pixel_input_packer.sv
// Byte-stream to 128-bit word packer feeding the histogram equalizer input memory.
// Publishes word/pixel counts at image end and fires a one-cycle start pulse.
// Optional build macro: INPUT_PACKER_PAD_EN (see pixel_lane_shifter).
module pixel_input_packer
    import pixel_input_packer_pkg::*;
#(
    parameter int MEM_DEPTH_WORDS = 65536
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pixel_valid,
    input  logic [PIXEL_W-1:0]  pixel_data,
    input  logic                pixel_last,
    output logic                pixel_ready,
    input  logic                core_busy,
    output logic                input_mem_WE,
    output logic [ADDR_W-1:0]   input_mem_waddr,
    output logic [WORD_W-1:0]   input_mem_wdata,
    output logic [DEPTH_W-1:0]  input_mem_depth,
    output logic [COUNT_W-1:0]  pixel_count,
    output logic                new_image_pulse,
    output logic                input_overflow_fault
);

    localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MEM_DEPTH_WORDS);
    localparam logic [COUNT_W-1:0] COUNT_MAX   = '1;

    state_t               state_reg;
    state_t               state_next;
    logic                 run_reg;
    logic [DEPTH_W-1:0]   word_cnt_reg;
    logic [COUNT_W-1:0]   pix_acc_reg;
    logic [DEPTH_W-1:0]   depth_reg;
    logic [COUNT_W-1:0]   count_reg;
    logic                 fault_reg;
    logic                 accept;
    logic                 start;
    logic                 mem_full;
    logic                 write_en;
    logic [WORD_W-1:0]    word;
    logic                 word_done;

    // IDLE gates new images on core_busy; FILL always accepts; FLUSH/PULSE hold the sender off.
    assign pixel_ready = (state_reg == FILL) ||
                         ((state_reg == IDLE) && run_reg && !core_busy);
    assign accept      = pixel_valid && pixel_ready;
    assign start       = accept && (state_reg == IDLE);
    assign mem_full    = (word_cnt_reg == DEPTH_LIMIT);
    assign write_en    = word_done && !mem_full;

    pixel_lane_shifter u_shifter (
        .clock      (clock),
        .reset      (reset),
        .accept     (accept),
        .pixel_data (pixel_data),
        .pixel_last (pixel_last),
        .word       (word),
        .word_done  (word_done)
    );

    // State register; run_reg keeps pixel_ready low until the first edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= 1'b1;
        end
    end

    // Next-state logic and the start pulse decode.
    always_comb begin
        state_next      = state_reg;
        new_image_pulse = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = pixel_last ? FLUSH : FILL;
                end
            end
            FILL: begin
                if (accept && pixel_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = PULSE;
            end
            PULSE: begin
                new_image_pulse = 1'b1;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word address counter; it stops advancing once memory is full, so it doubles as the depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_cnt_reg <= '0;
        end else if (start) begin
            word_cnt_reg <= '0;
        end else if (write_en) begin
            word_cnt_reg <= word_cnt_reg + 1'b1;
        end
    end

    // Saturating pixel accumulator; the first pixel of an image loads it with one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_acc_reg <= '0;
        end else if (start) begin
            pix_acc_reg <= COUNT_W'(1);
        end else if (accept && (pix_acc_reg != COUNT_MAX)) begin
            pix_acc_reg <= pix_acc_reg + 1'b1;
        end
    end

    // Sticky overflow flag: set when a word completes with no room, cleared by the next image.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_reg <= 1'b0;
        end else if (start) begin
            fault_reg <= 1'b0;
        end else if (word_done && mem_full) begin
            fault_reg <= 1'b1;
        end
    end

    // Publish the image totals during FLUSH, including a write landing in that same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_reg <= '0;
            count_reg <= '0;
        end else if (state_reg == FLUSH) begin
            depth_reg <= word_cnt_reg + DEPTH_W'(write_en);
            count_reg <= pix_acc_reg;
        end
    end

    assign input_mem_WE         = write_en;
    assign input_mem_waddr      = word_cnt_reg[ADDR_W-1:0];
    assign input_mem_wdata      = word;
    assign input_mem_depth      = depth_reg;
    assign pixel_count          = count_reg;
    assign input_overflow_fault = fault_reg;

endmodule

// File: tb/tb_pixel_input_packer.sv
// Scoreboard bench for pixel_input_packer: expected memory writes are queued as each image
// is built and popped by a write monitor; image-end totals and pulse timing are checked inline.
module tb_pixel_input_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_a, valid_b;
    logic [7:0]   data;
    logic         last;
    logic         core_busy;

    logic         ready_a, we_a, pulse_a, fault_a;
    logic [15:0]  waddr_a;
    logic [127:0] wdata_a;
    logic [16:0]  depth_a;
    logic [20:0]  count_a;

    logic         ready_b, we_b, pulse_b, fault_b;
    logic [15:0]  waddr_b;
    logic [127:0] wdata_b;
    logic [16:0]  depth_b;
    logic [20:0]  count_b;

    int tests = 0;
    int fails = 0;
    int we_count_a = 0;

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t exp_a[$];
    wr_t exp_b[$];

    always #5 clk = ~clk;

    pixel_input_packer dut_a (
        .clock                (clk),
        .reset                (rst),
        .pixel_valid          (valid_a),
        .pixel_data           (data),
        .pixel_last           (last),
        .pixel_ready          (ready_a),
        .core_busy            (core_busy),
        .input_mem_WE         (we_a),
        .input_mem_waddr      (waddr_a),
        .input_mem_wdata      (wdata_a),
        .input_mem_depth      (depth_a),
        .pixel_count          (count_a),
        .new_image_pulse      (pulse_a),
        .input_overflow_fault (fault_a)
    );

    pixel_input_packer #(.MEM_DEPTH_WORDS(2)) dut_b (
        .clock                (clk),
        .reset                (rst),
        .pixel_valid          (valid_b),
        .pixel_data           (data),
        .pixel_last           (last),
        .pixel_ready          (ready_b),
        .core_busy            (core_busy),
        .input_mem_WE         (we_b),
        .input_mem_waddr      (waddr_b),
        .input_mem_wdata      (wdata_b),
        .input_mem_depth      (depth_b),
        .pixel_count          (count_b),
        .new_image_pulse      (pulse_b),
        .input_overflow_fault (fault_b)
    );

    // Write monitor for the full-size instance.
    always @(negedge clk) begin
        wr_t e;
        if (we_a === 1'b1) begin
            tests++;
            we_count_a++;
            if (exp_a.size() == 0) begin
                fails++;
                $display("FAIL wr_a_unexpected: addr=%h data=%h required=no write", waddr_a, wdata_a);
            end else begin
                e = exp_a.pop_front();
                if (waddr_a !== e.addr || wdata_a !== e.data) begin
                    fails++;
                    $display("FAIL wr_a: addr=%h data=%h required addr=%h data=%h",
                             waddr_a, wdata_a, e.addr, e.data);
                end else begin
                    $display("[TB] wr_a addr=%h data=%h", waddr_a, wdata_a);
                end
            end
        end
    end

    // Write monitor for the two-word instance.
    always @(negedge clk) begin
        wr_t e;
        if (we_b === 1'b1) begin
            tests++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("FAIL wr_b_unexpected: addr=%h data=%h required=no write", waddr_b, wdata_b);
            end else begin
                e = exp_b.pop_front();
                if (waddr_b !== e.addr || wdata_b !== e.data) begin
                    fails++;
                    $display("FAIL wr_b: addr=%h data=%h required addr=%h data=%h",
                             waddr_b, wdata_b, e.addr, e.data);
                end else begin
                    $display("[TB] wr_b addr=%h data=%h", waddr_b, wdata_b);
                end
            end
        end
    end

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) valid_a = v;
        else          valid_b = v;
    endtask

    // Queue the expected words for an image, then stream it through the handshake.
    task automatic send_image(input int sel, input int n, input int base,
                              input bit do_last, input bit gaps, input int lim);
        logic [127:0] w;
        int           widx;
        int           guard;
        wr_t          e;
        w    = '0;
        widx = 0;
        for (int i = 0; i < n; i++) begin
            w[(i % 16) * 8 +: 8] = 8'(base + i);
            if ((i % 16) == 15) begin
                if (widx < lim) begin
                    e.addr = 16'(widx);
                    e.data = w;
                    if (sel == 0) exp_a.push_back(e);
                    else          exp_b.push_back(e);
                end
                widx++;
                w = '0;
            end
        end
`ifdef INPUT_PACKER_PAD_EN
        if (do_last && (n % 16) != 0 && widx < lim) begin
            e.addr = 16'(widx);
            e.data = w;
            if (sel == 0) exp_a.push_back(e);
            else          exp_b.push_back(e);
        end
`endif
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                set_valid(sel, 1'b0);
                last = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            set_valid(sel, 1'b1);
            data  = 8'(base + i);
            last  = do_last && (i == n - 1);
            guard = 0;
            while (((sel == 0) ? ready_a : ready_b) !== 1'b1) begin
                @(posedge clk);
                #1;
                guard++;
                if (guard > 200) begin
                    tests++;
                    fails++;
                    $display("FAIL send_ready_timeout: ready=0 required=1");
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        set_valid(sel, 1'b0);
        last = 1'b0;
    endtask

    // Called one cycle after the last handshake: final write now, totals and pulse next cycle.
    task automatic finish_check(input int sel, input logic exp_we, input int exp_depth,
                                input int exp_count, input logic exp_fault, input string name);
        tests++;
        if (((sel == 0) ? we_a : we_b) !== exp_we) begin
            fails++;
            $display("FAIL %s_final_we: we=%b required=%b", name, (sel == 0) ? we_a : we_b, exp_we);
        end
        tests++;
        if (((sel == 0) ? pulse_a : pulse_b) !== 1'b0) begin
            fails++;
            $display("FAIL %s_pulse_early: pulse=1 required=0", name);
        end
        @(posedge clk);
        #1;
        tests++;
        if (((sel == 0) ? pulse_a : pulse_b) !== 1'b1) begin
            fails++;
            $display("FAIL %s_pulse: pulse=0 required=1", name);
        end
        tests++;
        if (((sel == 0) ? depth_a : depth_b) !== 17'(exp_depth)) begin
            fails++;
            $display("FAIL %s_depth: depth=%0d required=%0d", name,
                     (sel == 0) ? depth_a : depth_b, exp_depth);
        end
        tests++;
        if (((sel == 0) ? count_a : count_b) !== 21'(exp_count)) begin
            fails++;
            $display("FAIL %s_count: count=%0d required=%0d", name,
                     (sel == 0) ? count_a : count_b, exp_count);
        end
        tests++;
        if (((sel == 0) ? fault_a : fault_b) !== exp_fault) begin
            fails++;
            $display("FAIL %s_fault: fault=%b required=%b", name,
                     (sel == 0) ? fault_a : fault_b, exp_fault);
        end
        @(posedge clk);
        #1;
        tests++;
        if (((sel == 0) ? pulse_a : pulse_b) !== 1'b0) begin
            fails++;
            $display("FAIL %s_pulse_width: pulse=1 required=0", name);
        end
        tests++;
        if (((sel == 0) ? exp_a.size() : exp_b.size()) != 0) begin
            fails++;
            $display("FAIL %s_missing_writes: pending=%0d required=0", name,
                     (sel == 0) ? exp_a.size() : exp_b.size());
        end
        $display("[TB] %s done depth=%0d count=%0d", name,
                 (sel == 0) ? depth_a : depth_b, (sel == 0) ? count_a : count_b);
    endtask

    task automatic check_zero_a(input string name);
        tests++;
        if (ready_a !== 1'b0 || we_a !== 1'b0 || waddr_a !== 16'h0 || wdata_a !== 128'h0 ||
            depth_a !== 17'h0 || count_a !== 21'h0 || pulse_a !== 1'b0 || fault_a !== 1'b0) begin
            fails++;
            $display("FAIL %s: rdy=%b we=%b addr=%h data=%h depth=%0d count=%0d pulse=%b fault=%b required all 0",
                     name, ready_a, we_a, waddr_a, wdata_a, depth_a, count_a, pulse_a, fault_a);
        end else begin
            $display("[TB] %s outputs zero", name);
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        valid_a   = 1'b0;
        valid_b   = 1'b0;
        data      = 8'h00;
        last      = 1'b0;
        core_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_a("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (ready_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: ready=%b required=1", ready_a);
        end
    endtask

    task automatic test_full_words;
        send_image(0, 32, 0, 1'b1, 1'b0, 65536);
        finish_check(0, 1'b1, 2, 32, 1'b0, "full_words");
    endtask

    task automatic test_partial_word;
        send_image(0, 20, 8'h80, 1'b1, 1'b0, 65536);
`ifdef INPUT_PACKER_PAD_EN
        finish_check(0, 1'b1, 2, 20, 1'b0, "partial_word");
`else
        finish_check(0, 1'b0, 1, 20, 1'b0, "partial_word");
`endif
    endtask

    task automatic test_core_busy;
        core_busy = 1'b1;
        valid_a   = 1'b1;
        data      = 8'h40;
        last      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (ready_a !== 1'b0) begin
                fails++;
                $display("FAIL busy_ready_%0d: ready=%b required=0", i, ready_a);
            end
        end
        core_busy = 1'b0;
        #1;
        tests++;
        if (ready_a !== 1'b1) begin
            fails++;
            $display("FAIL busy_release_ready: ready=%b required=1", ready_a);
        end
        send_image(0, 16, 8'h40, 1'b1, 1'b0, 65536);
        finish_check(0, 1'b1, 1, 16, 1'b0, "core_busy");
    endtask

    task automatic test_overflow;
        send_image(1, 48, 8'h10, 1'b1, 1'b0, 2);
        finish_check(1, 1'b0, 2, 48, 1'b1, "overflow");
        @(posedge clk);
        #1;
        tests++;
        if (fault_b !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: fault=%b required=1", fault_b);
        end
        send_image(1, 16, 8'h20, 1'b1, 1'b0, 2);
        finish_check(1, 1'b1, 1, 16, 1'b0, "overflow_clear");
    endtask

    task automatic test_random_gaps;
        int start_count;
        start_count = we_count_a;
        send_image(0, 64, 8'hA0, 1'b1, 1'b1, 65536);
        finish_check(0, 1'b1, 4, 64, 1'b0, "random_gaps");
        tests++;
        if (we_count_a - start_count != 4) begin
            fails++;
            $display("FAIL gaps_we_count: writes=%0d required=4", we_count_a - start_count);
        end
    endtask

    task automatic test_reset_mid_image;
        send_image(0, 10, 8'h55, 1'b0, 1'b0, 65536);
        #2;
        rst = 1'b1;
        #1;
        check_zero_a("reset_mid_image");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_image(0, 16, 8'h30, 1'b1, 1'b0, 65536);
        finish_check(0, 1'b1, 1, 16, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_partial_word();
        test_core_busy();
        test_overflow();
        test_random_gaps();
        test_reset_mid_image();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
